// File: rtl/mips_mem_pkg.sv
// Shared opcodes, FSM encoding and lane helpers for the MEM stage.
// Everything here is decoded from the EX/MEM instruction and the low address bits.
package mips_mem_pkg;

    localparam logic [5:0] LB  = 6'h20;
    localparam logic [5:0] LH  = 6'h21;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LBU = 6'h24;
    localparam logic [5:0] LHU = 6'h25;
    localparam logic [5:0] SB  = 6'h28;
    localparam logic [5:0] SH  = 6'h29;
    localparam logic [5:0] SW  = 6'h2B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        logic        write_en;
        logic [4:0]  write_addr;
        logic [31:0] data;
    } wb_bundle_t;

    function automatic logic is_load_op(input logic [5:0] op);
        return op inside {LB, LH, LW, LBU, LHU};
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        return op inside {SB, SH, SW};
    endfunction

    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] a);
        case (op)
            LH, LHU, SH: return a[0];
            LW, SW:      return |a;
            default:     return 1'b0;
        endcase
    endfunction

    // Loads use the same lane pattern as the matching store width.
    function automatic logic [3:0] byte_enable(input logic [5:0] op, input logic [1:0] a);
        case (op)
            LB, LBU, SB: return 4'b0001 << a;
            LH, LHU, SH: return a[1] ? 4'b1100 : 4'b0011;
            default:     return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [5:0] op, input logic [31:0] data);
        case (op)
            SB:      return {4{data[7:0]}};
            SH:      return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data RAM request/acknowledge bus between the MEM stage (master) and the RAM (slave).
interface mem_access_stage_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/mem_access_stage_load_formatter.sv
// Picks the addressed lane out of a RAM word and sign- or zero-extends it.
module load_formatter
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [5:0]  op,
    input  logic [1:0]  a,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (a)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = a[1] ? rdata[31:16] : rdata[15:0];

        result = rdata;
        case (op)
            LB:      result = {{24{byte_sel[7]}}, byte_sel};
            LBU:     result = {24'h0, byte_sel};
            LH:      result = {{16{half_sel[15]}}, half_sel};
            LHU:     result = {16'h0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage and MEM/WB register: runs data RAM accesses over req/ack and
// registers the write-back bundle, stalling upstream while an access is in flight.
//
// state  | meaning
// S_IDLE | no access outstanding; pass-through, or issue a request this cycle
// S_WAIT | request held on the bus until ack or timeout
// S_DONE | access finished while cpu_en was low; hold wb_* and do not reissue
module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_en,
    input  logic                exceptClear,
    input  logic [31:0]         mem_instruction,
    input  logic [31:0]         mem_pc,
    input  logic                mem_ifWriteRegsFile,
    input  logic                mem_memOutOrAluOutWriteBackToRegFile,
    input  logic                mem_ifWriteMem,
    input  logic [4:0]          mem_registerWriteAddress,
    input  logic [31:0]         mem_aluOutput,
    input  logic [31:0]         mem_writeDataToDataRAM,
    mem_access_stage_if.master  dmem,
    output logic                mem_stall,
    output logic                mem_addrExcept,
    output logic [31:0]         wb_instruction,
    output logic [31:0]         wb_pc,
    output logic                wb_ifWriteRegsFile,
    output logic [4:0]          wb_registerWriteAddress,
    output logic [31:0]         wb_regWriteData,
    output logic                wb_busError
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    mem_state_t state;
    logic [7:0] wait_cnt;
    logic       flush_pending;
    wb_bundle_t wb_q;

    logic [5:0]  op;
    logic        valid_load;
    logic        valid_store;
    logic        mis;
    logic        access;
    logic        issue;
    logic        timeout_hit;
    logic        wb_write_en;
    logic [31:0] load_result;
    wb_bundle_t  wb_pass;
    wb_bundle_t  wb_mem;
    wb_bundle_t  wb_fault;

    assign op          = mem_instruction[31:26];
    assign valid_load  = is_load_op(op) & mem_memOutOrAluOutWriteBackToRegFile;
    assign valid_store = is_store_op(op) & mem_ifWriteMem;
    assign mis         = (valid_load | valid_store) & misaligned(op, mem_aluOutput[1:0]);
    assign access      = (valid_load | valid_store) & ~mis;
    assign issue       = (state == S_IDLE) & access & cpu_en & ~exceptClear;
    assign timeout_hit = (state == S_WAIT) & (wait_cnt == TIMEOUT_LIMIT);
    assign wb_write_en = mem_ifWriteRegsFile & (mem_registerWriteAddress != 5'd0) & ~mis;

    load_formatter u_load_formatter (
        .rdata  (dmem.rdata),
        .op     (op),
        .a      (mem_aluOutput[1:0]),
        .result (load_result)
    );

    // Bus outputs and stall are forced low while rst is asserted so a
    // reset during WAIT abandons the request in the same cycle.
    assign dmem.req       = rst & (issue | ((state == S_WAIT) & ~timeout_hit));
    assign dmem.we        = dmem.req & valid_store;
    assign dmem.be        = dmem.req ? byte_enable(op, mem_aluOutput[1:0]) : 4'b0000;
    assign dmem.addr      = rst ? {mem_aluOutput[31:2], 2'b00} : 32'h0;
    assign dmem.wdata     = rst ? store_lanes(op, mem_writeDataToDataRAM) : 32'h0;
    assign mem_stall      = rst & (issue | ((state == S_WAIT) & ~timeout_hit & ~dmem.ack));
    assign mem_addrExcept = rst & mis;

    always_comb begin
        wb_pass             = '0;
        wb_pass.instruction = mem_instruction;
        wb_pass.pc          = mem_pc;
        wb_pass.write_en    = wb_write_en;
        wb_pass.write_addr  = mem_registerWriteAddress;
        wb_pass.data        = mem_aluOutput;

        wb_mem      = wb_pass;
        wb_mem.data = valid_load ? load_result : mem_aluOutput;

        wb_fault          = wb_pass;
        wb_fault.write_en = 1'b0;
        wb_fault.data     = 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            wait_cnt      <= 8'd0;
            flush_pending <= 1'b0;
            wb_q          <= '0;
            wb_busError   <= 1'b0;
        end else begin
            wb_busError <= 1'b0;
            case (state)
                S_IDLE: begin
                    wait_cnt      <= 8'd0;
                    flush_pending <= 1'b0;
                    if (exceptClear) begin
                        wb_q <= '0;
                    end else if (cpu_en) begin
                        if (access) begin
                            // Bubble to WB while the RAM works; data lands on ack.
                            wb_q  <= '0;
                            state <= S_WAIT;
                        end else begin
                            wb_q <= wb_pass;
                        end
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (timeout_hit) begin
                        wb_q          <= wb_fault;
                        wb_busError   <= 1'b1;
                        flush_pending <= 1'b0;
                        state         <= S_IDLE;
                    end else if (dmem.ack) begin
                        if (flush_pending | exceptClear) begin
                            wb_q <= '0;
                        end else begin
                            wb_q <= wb_mem;
                        end
                        flush_pending <= 1'b0;
                        state         <= cpu_en ? S_IDLE : S_DONE;
                    end else if (exceptClear) begin
                        flush_pending <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (cpu_en) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign wb_instruction          = wb_q.instruction;
    assign wb_pc                   = wb_q.pc;
    assign wb_ifWriteRegsFile      = wb_q.write_en;
    assign wb_registerWriteAddress = wb_q.write_addr;
    assign wb_regWriteData         = wb_q.data;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed corner cases plus a random
// instruction stream compared against a byte-level memory model.
module tb_mem_access_stage;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic        exceptClear;
    logic [31:0] mem_instruction;
    logic [31:0] mem_pc;
    logic        mem_ifWriteRegsFile;
    logic        mem_memOutOrAluOutWriteBackToRegFile;
    logic        mem_ifWriteMem;
    logic [4:0]  mem_registerWriteAddress;
    logic [31:0] mem_aluOutput;
    logic [31:0] mem_writeDataToDataRAM;
    logic        mem_stall;
    logic        mem_addrExcept;
    logic [31:0] wb_instruction;
    logic [31:0] wb_pc;
    logic        wb_ifWriteRegsFile;
    logic [4:0]  wb_registerWriteAddress;
    logic [31:0] wb_regWriteData;
    logic        wb_busError;

    mem_access_stage_if dmem ();

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk                                  (clk),
        .rst                                  (rst),
        .cpu_en                               (cpu_en),
        .exceptClear                          (exceptClear),
        .mem_instruction                      (mem_instruction),
        .mem_pc                               (mem_pc),
        .mem_ifWriteRegsFile                  (mem_ifWriteRegsFile),
        .mem_memOutOrAluOutWriteBackToRegFile (mem_memOutOrAluOutWriteBackToRegFile),
        .mem_ifWriteMem                       (mem_ifWriteMem),
        .mem_registerWriteAddress             (mem_registerWriteAddress),
        .mem_aluOutput                        (mem_aluOutput),
        .mem_writeDataToDataRAM               (mem_writeDataToDataRAM),
        .dmem                                 (dmem),
        .mem_stall                            (mem_stall),
        .mem_addrExcept                       (mem_addrExcept),
        .wb_instruction                       (wb_instruction),
        .wb_pc                                (wb_pc),
        .wb_ifWriteRegsFile                   (wb_ifWriteRegsFile),
        .wb_registerWriteAddress              (wb_registerWriteAddress),
        .wb_regWriteData                      (wb_regWriteData),
        .wb_busError                          (wb_busError)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // RAM behind the bus, and an independent byte-addressed reference memory.
    logic [31:0] ram [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    int          ram_delay = 0;
    bit          ram_mute = 1'b0;
    int          req_cycles = 0;
    logic [31:0] resp_word;

    function automatic logic [31:0] ram_read(input logic [31:0] wa);
        return ram.exists(wa) ? ram[wa] : 32'h0;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h0;
    endfunction

    function automatic void preload(input logic [31:0] a, input logic [31:0] w);
        logic [31:0] base;
        base = {a[31:2], 2'b00};
        ram[base] = w;
        for (int i = 0; i < 4; i++) ref_mem[base + 32'(i)] = w[8*i +: 8];
    endfunction

    // Acks no earlier than the second request cycle, plus ram_delay extra cycles.
    initial begin
        dmem.ack   = 1'b0;
        dmem.rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            dmem.ack = 1'b0;
            if (dmem.req === 1'b1 && !ram_mute) begin
                req_cycles++;
                if (req_cycles >= 2 + ram_delay) begin
                    resp_word  = ram_read(dmem.addr);
                    dmem.rdata = resp_word;
                    if (dmem.we === 1'b1) begin
                        for (int i = 0; i < 4; i++)
                            if (dmem.be[i]) resp_word[8*i +: 8] = dmem.wdata[8*i +: 8];
                        ram[dmem.addr] = resp_word;
                    end
                    dmem.ack   = 1'b1;
                    req_cycles = 0;
                end
            end else begin
                req_cycles = 0;
            end
        end
    end

    function automatic int m_size(input logic [5:0] op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic bit m_is_load(input logic [5:0] op);
        return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
    endfunction

    function automatic bit m_misaligned(input logic [5:0] op, input logic [31:0] a);
        int sz;
        sz = m_size(op);
        return (sz > 1) && ((int'(a[1:0]) % sz) != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] a);
        int     sz;
        longint v;
        sz = m_size(op);
        v  = 0;
        for (int i = 0; i < sz; i++) v = v + (longint'(ref_byte(a + 32'(i))) << (8 * i));
        if ((op == LB || op == LH) && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return 32'(v);
    endfunction

    function automatic void m_store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < m_size(op); i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] d);
        case (m_size(op))
            1:       return {24'h0, d[7:0]} * 32'h0101_0101;
            2:       return {16'h0, d[15:0]} * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sdata,
                         input logic [4:0] rd);
        logic [31:0] r;
        bit ld, st;
        ld = m_is_load(op);
        st = (m_size(op) > 0) && !ld;
        r = $urandom;
        mem_instruction = {op, r[25:0]};
        r = $urandom;
        mem_pc = {r[31:2], 2'b00};
        mem_ifWriteRegsFile                  = !st;
        mem_memOutOrAluOutWriteBackToRegFile = ld;
        mem_ifWriteMem                       = st;
        mem_registerWriteAddress             = rd;
        mem_aluOutput                        = a;
        mem_writeDataToDataRAM               = sdata;
    endtask

    task automatic drive_nop();
        drive(6'h00, 32'h0000_0000, 32'h0, 5'd0);
    endtask

    // Called at posedge+1; returns at posedge+1 after the instruction reaches WB.
    task automatic run_instr(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sdata,
                             input logic [4:0] rd, input int delay);
        bit ld, st, mis, acc;
        logic [31:0] exp_data, exp_be, instr, pc;
        int stalls;
        ld  = m_is_load(op);
        st  = (m_size(op) > 0) && !ld;
        mis = m_misaligned(op, a);
        acc = (ld || st) && !mis;
        exp_data = (ld && acc) ? m_load(op, a) : a;
        exp_be   = 32'((((1 << m_size(op)) - 1) << int'(a[1:0])) & 15);
        drive(op, a, sdata, rd);
        instr = mem_instruction;
        pc    = mem_pc;
        ram_delay   = delay;
        cpu_en      = 1'b1;
        exceptClear = 1'b0;
        #3;
        check("addr_except", mem_addrExcept, mis);
        check("req_issue", dmem.req, acc);
        if (acc) begin
            check("bus_addr", dmem.addr, {a[31:2], 2'b00});
            check("bus_we", dmem.we, st);
            if (st) begin
                check("bus_be", dmem.be, exp_be);
                check("bus_wdata", dmem.wdata, m_wdata(op, sdata));
            end
        end
        stalls = 0;
        while (mem_stall === 1'b1 && stalls < 20) begin
            stalls++;
            @(posedge clk);
            #4;
        end
        check("stall_len", stalls, acc ? 1 + delay : 0);
        @(posedge clk);
        #1;
        check("wb_instruction", wb_instruction, instr);
        check("wb_pc", wb_pc, pc);
        check("wb_write_en", wb_ifWriteRegsFile, (!st) && (rd != 0) && !mis);
        check("wb_write_addr", wb_registerWriteAddress, rd);
        check("wb_data", wb_regWriteData, exp_data);
        check("wb_bus_error", wb_busError, 0);
        if (st && acc) m_store(op, a, sdata);
    endtask

    logic [5:0] op_tab [10] = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 6'h00, 6'h08};

    initial begin
        int n;
        logic [31:0] exp;
        logic [5:0]  op;
        rst         = 1'b0;
        cpu_en      = 1'b1;
        exceptClear = 1'b0;
        for (int w = 0; w < 16; w++) preload(32'h100 + 32'(4 * w), $urandom);
        preload(32'h1000, 32'h80FF_FF01);
        preload(32'h108, 32'hDEAD_BEEF);
        drive(LW, 32'h100, 32'h0, 5'd3);

        // reset with an access pending
        @(posedge clk);
        #1;
        repeat (2) begin
            #3;
            check("rst_req", dmem.req, 0);
            check("rst_stall", mem_stall, 0);
            check("rst_wb_we", wb_ifWriteRegsFile, 0);
            check("rst_wb_data", wb_regWriteData, 0);
            check("rst_wb_instr", wb_instruction, 0);
            check("rst_wb_berr", wb_busError, 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        drive_nop();
        @(posedge clk);
        #1;

        // signed byte load from the top lane
        run_instr(LB, 32'h1003, 32'h0, 5'd2, 0);
        check("lb_value", wb_regWriteData, 32'hFFFF_FF80);

        // halfword store to the upper lane, read back
        run_instr(SH, 32'h2002, 32'h1234_ABCD, 5'd0, 0);
        run_instr(LHU, 32'h2002, 32'h0, 5'd7, 1);
        check("sh_readback_hu", wb_regWriteData, 32'h0000_ABCD);
        run_instr(LW, 32'h2000, 32'h0, 5'd7, 0);
        check("sh_readback_w", wb_regWriteData, 32'hABCD_0000);

        // misaligned word load
        run_instr(LW, 32'h1001, 32'h0, 5'd3, 0);

        // timeout: RAM never answers
        ram_mute = 1'b1;
        drive(LW, 32'h100, 32'h0, 5'd4);
        #3;
        n = 0;
        while (dmem.req === 1'b1 && n < 20) begin
            n++;
            @(posedge clk);
            #4;
        end
        check("to_req_cycles", n, 5);
        check("to_stall_drop", mem_stall, 0);
        @(posedge clk);
        #1;
        check("to_bus_error", wb_busError, 1);
        check("to_write_en", wb_ifWriteRegsFile, 0);
        drive_nop();
        ram_mute = 1'b0;
        @(posedge clk);
        #1;
        check("to_bus_error_pulse", wb_busError, 0);

        // ack while cpu_en low -> held, no reissue
        drive(LW, 32'h104, 32'h0, 5'd9);
        exp = m_load(LW, 32'h104);
        ram_delay = 1;
        #3;
        check("hold_issue", dmem.req, 1);
        @(posedge clk);
        #1;
        cpu_en = 1'b0;
        #3;
        n = 0;
        while (dmem.ack !== 1'b1 && n < 10) begin
            n++;
            @(posedge clk);
            #4;
        end
        check("hold_ack_seen", dmem.ack, 1);
        @(posedge clk);
        #1;
        check("hold_data", wb_regWriteData, exp);
        check("hold_we", wb_ifWriteRegsFile, 1);
        repeat (3) begin
            #3;
            check("hold_no_req", dmem.req, 0);
            check("hold_no_stall", mem_stall, 0);
            @(posedge clk);
            #1;
            check("hold_wb", wb_regWriteData, exp);
        end
        cpu_en = 1'b1;
        #3;
        check("hold_no_reissue", dmem.req, 0);
        @(posedge clk);
        #1;
        drive_nop();
        @(posedge clk);
        #1;

        // flush during WAIT
        drive(LW, 32'h108, 32'h0, 5'd5);
        ram_delay = 2;
        #3;
        check("flush_issue", dmem.req, 1);
        @(posedge clk);
        #1;
        exceptClear = 1'b1;
        @(posedge clk);
        #1;
        exceptClear = 1'b0;
        #3;
        n = 0;
        while (dmem.ack !== 1'b1 && n < 10) begin
            n++;
            @(posedge clk);
            #4;
        end
        check("flush_ack_seen", dmem.ack, 1);
        @(posedge clk);
        #1;
        check("flush_wb_we", wb_ifWriteRegsFile, 0);
        check("flush_wb_data", wb_regWriteData, 0);
        check("flush_wb_instr", wb_instruction, 0);
        drive_nop();
        @(posedge clk);
        #1;

        // flush in IDLE suppresses the request
        drive(LW, 32'h10C, 32'h0, 5'd6);
        exceptClear = 1'b1;
        #3;
        check("idle_flush_req", dmem.req, 0);
        check("idle_flush_stall", mem_stall, 0);
        @(posedge clk);
        #1;
        check("idle_flush_wb_we", wb_ifWriteRegsFile, 0);
        exceptClear = 1'b0;
        drive_nop();
        @(posedge clk);
        #1;

        // random stream
        for (int k = 0; k < 80; k++) begin
            op = op_tab[$urandom_range(0, 9)];
            if (m_size(op) > 0)
                run_instr(op, 32'h100 + 32'($urandom_range(0, 63)), $urandom,
                          5'($urandom_range(0, 31)), $urandom_range(0, 2));
            else
                run_instr(op, $urandom, $urandom, 5'($urandom_range(0, 31)), 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
